// File: rtl/hd44780_lcd_sequencer.sv
// HD44780 command/data sequencer: runs the 4-bit power-on init, then splits host
// bytes into two nybble transfers and enforces each command's execution delay.
module hd44780_lcd_sequencer #(
  parameter int TIMER_BITS    = 23,
  parameter int DELAY_POWERUP = 4800000,
  parameter int DELAY_4P1MS   = 196800,
  parameter int DELAY_100US   = 4800,
  parameter int DELAY_53US    = 2544,
  parameter int DELAY_3MS     = 144000
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       STB_I,
  input  logic [7:0] DAT_I,
  input  logic       RS_I,
  output logic       ACK_O,
  output logic       busy_o,
  output logic       ready_o,
  output logic       nyb_stb_o,
  output logic [3:0] nyb_o,
  output logic       nyb_rs_o,
  input  logic       nyb_done_i
);

  localparam logic [3:0] PWR_WAIT  = 4'd0;
  localparam logic [3:0] INIT_STEP = 4'd1;
  localparam logic [3:0] IDLE      = 4'd2;
  localparam logic [3:0] SEND_HI   = 4'd3;
  localparam logic [3:0] WAIT_HI   = 4'd4;
  localparam logic [3:0] SEND_LO   = 4'd5;
  localparam logic [3:0] WAIT_LO   = 4'd6;
  localparam logic [3:0] POST_DLY  = 4'd7;
  localparam logic [3:0] DONE      = 4'd8;

  localparam logic [TIMER_BITS-1:0] LOAD_PWR  = TIMER_BITS'(DELAY_POWERUP);
  localparam logic [TIMER_BITS-1:0] LOAD_4P1  = TIMER_BITS'(DELAY_4P1MS - 1);
  localparam logic [TIMER_BITS-1:0] LOAD_100  = TIMER_BITS'(DELAY_100US - 1);
  localparam logic [TIMER_BITS-1:0] LOAD_53   = TIMER_BITS'(DELAY_53US - 1);
  localparam logic [TIMER_BITS-1:0] LOAD_3MS  = TIMER_BITS'(DELAY_3MS - 1);
  localparam logic [TIMER_BITS-1:0] ONE       = TIMER_BITS'(1);

  logic [3:0]            state;
  logic [TIMER_BITS-1:0] cnt;
  logic [7:0]            dat;
  logic                  rs;
  logic                  lo_phase;
  logic                  single;
  logic [2:0]            item;
  logic                  ready;

  // Init single nybbles ride the byte path as {nyb,4'h0} with only the high half sent.
  function automatic logic [8:0] init_item(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: init_item = 9'h130;
      3'd3:             init_item = 9'h120;
      3'd4:             init_item = 9'h028;
      3'd5:             init_item = 9'h00C;
      3'd6:             init_item = 9'h001;
      default:          init_item = 9'h006;
    endcase
  endfunction

  function automatic logic [TIMER_BITS-1:0] single_dly(input logic [2:0] i);
    case (i)
      3'd0:    single_dly = LOAD_4P1;
      3'd1:    single_dly = LOAD_100;
      default: single_dly = LOAD_53;
    endcase
  endfunction

  logic [TIMER_BITS-1:0] byte_dly;
  always_comb begin
    byte_dly = LOAD_53;
    if (!rs && (dat == 8'h01 || dat == 8'h02 || dat == 8'h03))
      byte_dly = LOAD_3MS;
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state    <= PWR_WAIT;
      cnt      <= LOAD_PWR;
      dat      <= '0;
      rs       <= 1'b0;
      lo_phase <= 1'b0;
      single   <= 1'b0;
      item     <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        PWR_WAIT: begin
          if (cnt == '0) begin
            {single, dat} <= init_item(3'd0);
            rs       <= 1'b0;
            lo_phase <= 1'b0;
            item     <= '0;
            state    <= INIT_STEP;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        INIT_STEP: state <= WAIT_HI;
        IDLE, DONE: begin
          if (STB_I) begin
            dat      <= DAT_I;
            rs       <= RS_I;
            single   <= 1'b0;
            lo_phase <= 1'b0;
            state    <= SEND_HI;
          end else begin
            state <= IDLE;
          end
        end
        SEND_HI: state <= WAIT_HI;
        WAIT_HI: begin
          if (nyb_done_i) begin
            if (single) begin
              cnt   <= single_dly(item);
              state <= POST_DLY;
            end else begin
              lo_phase <= 1'b1;
              state    <= SEND_LO;
            end
          end
        end
        SEND_LO: state <= WAIT_LO;
        WAIT_LO: begin
          if (nyb_done_i) begin
            cnt   <= byte_dly;
            state <= POST_DLY;
          end
        end
        POST_DLY: begin
          if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else if (ready) begin
            state <= DONE;
          end else if (item == 3'd7) begin
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            item          <= item + 3'd1;
            {single, dat} <= init_item(item + 3'd1);
            lo_phase      <= 1'b0;
            state         <= INIT_STEP;
          end
        end
        default: state <= PWR_WAIT;
      endcase
    end
  end

  assign nyb_stb_o = (state == INIT_STEP) || (state == SEND_HI) || (state == SEND_LO);
  assign nyb_o     = lo_phase ? dat[3:0] : dat[7:4];
  assign nyb_rs_o  = rs;
  assign ACK_O     = (state == DONE);
  assign busy_o    = (state != IDLE) && (state != DONE);
  assign ready_o   = ready;

endmodule

// File: tb/tb_hd44780_lcd_sequencer.sv
// Directed bench for hd44780_lcd_sequencer with a 4-cycle nybble-sender model.
module tb_hd44780_lcd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stb = 1'b0;
  logic [7:0] dat = '0;
  logic       rs = 1'b0;
  logic       ack, busy, ready, nyb_stb, nyb_rs, nyb_done;
  logic [3:0] nyb;
  logic [3:0] sr;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int ack_cnt  = 0;
  int stb_cnt  = 0;

  logic [3:0] init_nyb [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};
  int         init_gap [12] = '{21, 11, 6, 4, 4, 1, 4, 1, 4, 1, 9, 1};

  hd44780_lcd_sequencer #(
    .TIMER_BITS(23), .DELAY_POWERUP(20), .DELAY_4P1MS(10),
    .DELAY_100US(5), .DELAY_53US(3), .DELAY_3MS(8)
  ) dut (
    .CLK_I(clk), .RST_I(rst_n), .STB_I(stb), .DAT_I(dat), .RS_I(rs),
    .ACK_O(ack), .busy_o(busy), .ready_o(ready), .nyb_stb_o(nyb_stb),
    .nyb_o(nyb), .nyb_rs_o(nyb_rs), .nyb_done_i(nyb_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else        sr <= {sr[2:0], nyb_stb};
  assign nyb_done = sr[3];

  always @(negedge clk) begin
    if (ack)     ack_cnt++;
    if (nyb_stb) stb_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // which: 0 nyb_stb, 1 nyb_done, 2 ACK, 3 ready
  task automatic wait_sig(input int which, output int c);
    int hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((which == 0 && nyb_stb) || (which == 1 && nyb_done) ||
          (which == 2 && ack) || (which == 3 && ready)) begin
        hit = 1;
        break;
      end
    end
    c = cyc;
    check($sformatf("wait_%0d", which), hit, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_stb"}, nyb_stb, 0);
    check({tag, "_nyb"}, nyb, 0);
    check({tag, "_rs"}, nyb_rs, 0);
  endtask

  task automatic run_init(input int r0);
    int c, d, a0;
    d  = r0;
    a0 = ack_cnt;
    for (int i = 0; i < 12; i++) begin
      wait_sig(0, c);
      check($sformatf("init_nyb%0d", i), nyb, init_nyb[i]);
      check($sformatf("init_rs%0d", i), nyb_rs, 0);
      check($sformatf("init_gap%0d", i), c - d, init_gap[i]);
      check($sformatf("init_rdy%0d", i), ready, 0);
      wait_sig(1, d);
      check($sformatf("init_hold%0d", i), nyb, init_nyb[i]);
    end
    wait_sig(3, c);
    check("ready_gap", c - d, 4);
    check("ready_busy", busy, 0);
    check("init_no_ack", ack_cnt - a0, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic r, input int gap);
    int t, c, d;
    stb = 1'b1; dat = b; rs = r; t = cyc;
    wait_sig(0, c);
    stb = 1'b0;
    check("hi_lat", c - t, 1);
    check("hi_nyb", nyb, b[7:4]);
    check("hi_rs", nyb_rs, r);
    check("hi_busy", busy, 1);
    wait_sig(1, d);
    wait_sig(0, c);
    check("lo_gap", c - d, 1);
    check("lo_nyb", nyb, b[3:0]);
    check("lo_rs", nyb_rs, r);
    wait_sig(1, d);
    check("lo_hold", nyb, b[3:0]);
    check("dly_busy", busy, 1);
    wait_sig(2, c);
    check("ack_gap", c - d, gap);
    check("ack_busy", busy, 0);
    @(negedge clk);
    check("post_ack", ack, 0);
    check("post_busy", busy, 0);
  endtask

  initial begin
    int c, d, n0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    run_init(cyc);

    send_byte(8'h41, 1'b1, 4);
    send_byte(8'h01, 1'b0, 9);
    send_byte(8'h02, 1'b1, 4);

    // Back-to-back: STB held high through the first byte, second byte taken on ACK.
    n0 = stb_cnt;
    stb = 1'b1; dat = 8'h55; rs = 1'b1;
    wait_sig(0, c);
    check("b2b_hi1", nyb, 4'h5);
    wait_sig(1, d);
    wait_sig(0, c);
    check("b2b_lo1", nyb, 4'h5);
    wait_sig(1, d);
    wait_sig(2, c);
    check("b2b_ack1", c - d, 4);
    dat = 8'h6A;
    wait_sig(0, d);
    stb = 1'b0;
    check("b2b_accept", d - c, 1);
    check("b2b_hi2", nyb, 4'h6);
    wait_sig(1, d);
    wait_sig(0, c);
    check("b2b_lo2", nyb, 4'hA);
    wait_sig(1, d);
    wait_sig(2, c);
    check("b2b_ack2", c - d, 4);
    repeat (10) @(negedge clk);
    check("b2b_nyb_count", stb_cnt - n0, 4);

    // Reset while waiting for the low-nybble done.
    stb = 1'b1; dat = 8'h33; rs = 1'b1;
    wait_sig(0, c);
    stb = 1'b0;
    wait_sig(1, d);
    wait_sig(0, c);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    check_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    run_init(cyc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
